// File: rtl/prog_loader.sv
// prog_loader -- streams a length-prefixed program image into a byte-wide RAM
// and holds the processor in reset until the image is known-good.
//
// Session: start pulse -> length byte N (8'h00 = 256) -> N payload bytes,
// each written to RAM at START_ADDR, START_ADDR+1, ... (mod 256) one cycle
// after it is accepted. With LOADER_CHECKSUM_EN defined a trailing checksum
// byte (8-bit sum of the payload) is compared before the image is released.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   start      one-cycle pulse, begins a session from IDLE/DONE/ERROR
//   rx_valid   byte stream valid
//   rx_data    byte stream data
//   rx_ready   loader can accept a byte this cycle
//   mem_we     RAM write strobe (one cycle per payload byte)
//   mem_addr   RAM write address
//   mem_data   RAM write data
//   cpu_reset  processor hold, low only in DONE
//   done       load completed successfully
//   error      checksum mismatch (tied 0 without LOADER_CHECKSUM_EN)
//
// Optional feature macro: LOADER_CHECKSUM_EN
module prog_loader #(
  parameter logic [7:0] START_ADDR = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       cpu_reset,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_LOAD  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t     state, nxt;
  logic [7:0] cnt;   // remaining payload bytes; 0 at load time means 256
  logic [7:0] addr;  // address of the next payload byte
  logic       last;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  assign last = (cnt == 8'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt      = state;
    rx_ready = 1'b0;
    case (state)
      S_IDLE: if (start) nxt = S_LEN;
      S_LEN: begin
        rx_ready = 1'b1;
        if (rx_valid) nxt = S_LOAD;
      end
      S_LOAD: begin
        rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (rx_valid && last) nxt = S_CHECK;
`else
        if (rx_valid && last) nxt = S_DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        rx_ready = 1'b1;
        if (rx_valid) nxt = (rx_data == sum) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE:  if (start) nxt = S_LEN;
      S_ERROR: if (start) nxt = S_LEN;
      default: nxt = S_IDLE;
    endcase
  end

  // Payload bytes are registered with their address so the RAM sees a clean
  // one-cycle write the cycle after acceptance; the last write therefore
  // lands in the first DONE (or CHECK) cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= 8'h00;
      addr     <= 8'h00;
      mem_we   <= 1'b0;
      mem_addr <= 8'h00;
      mem_data <= 8'h00;
`ifdef LOADER_CHECKSUM_EN
      sum      <= 8'h00;
`endif
    end else begin
      mem_we <= 1'b0;
      if (state == S_LEN && rx_valid) begin
        cnt  <= rx_data;
        addr <= START_ADDR;
`ifdef LOADER_CHECKSUM_EN
        sum  <= 8'h00;
`endif
      end
      if (state == S_LOAD && rx_valid) begin
        mem_we   <= 1'b1;
        mem_addr <= addr;
        mem_data <= rx_data;
        addr     <= addr + 8'd1;
        cnt      <= cnt - 8'd1;
`ifdef LOADER_CHECKSUM_EN
        sum      <= sum + rx_data;
`endif
      end
    end
  end

  assign done      = (state == S_DONE);
  assign cpu_reset = (state != S_DONE);
`ifdef LOADER_CHECKSUM_EN
  assign error     = (state == S_ERROR);
`else
  assign error     = 1'b0;
`endif

endmodule
